// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a registered-read byte FIFO one byte at a time and
// sends each byte as an 8N1 frame (start, 8 data bits LSB first, stop) on tx.
// It also keeps a wrapping 16-bit count of the frames it has completed.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_read,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             fifo_read_q, fifo_read_d;
  logic             busy_q, busy_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // Next-state logic: a pop is only requested from IDLE with a non-empty FIFO,
  // the read data is captured two edges later, then each bit lasts CLKS_PER_BIT cycles.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    tx_d        = tx_q;
    fifo_read_d = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_d     = READ;
          fifo_read_d = 1'b1;
        end
      end
      READ: begin
        state_d = LATCH;
      end
      LATCH: begin
        shreg_d = fifo_dout;
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (baud_end) begin
          baud_d    = '0;
          tx_d      = shreg_q[0];
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q != 3'd7) begin
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            tx_d    = 1'b1;
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d      = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any frame in flight with tx high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      tx_q        <= 1'b1;
      fifo_read_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      fifo_read_q <= fifo_read_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign fifo_read = fifo_read_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx from a queue-based FIFO model and
// predicts every tx bit from the frame layout (start, LSB-first data, stop).
module tb_fifo_uart_tx;

  localparam int C = 4;
  localparam int FRAME_END = 2 + 10 * C;

  logic        clk;
  logic        rst;
  logic        tx_en;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        fifo_read;
  logic        tx;
  logic        busy;
  logic [15:0] frame_cnt;

  logic [7:0]  fifoQ[$];
  int          checks;
  int          errors;
  int          modelCnt;
  int          cycle;

  fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_read  (fifo_read),
    .tx         (tx),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and reports tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input logic newRst, input logic newEn);
    rst   = newRst;
    tx_en = newEn;
  endtask

  // Advance one clock. The FIFO model pops on the edge that sees fifo_read high
  // and presents the byte before the following edge (registered read).
  task automatic tick();
    logic rdSeen;
    rdSeen = fifo_read;
    @(posedge clk);
    @(negedge clk);
    cycle++;
    if (rdSeen === 1'b1 && fifoQ.size() > 0) fifo_dout = fifoQ.pop_front();
    fifo_empty = (fifoQ.size() == 0);
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifoQ.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // Wait for a pop, then check every cycle of the frame against the bit layout.
  // expWait: required number of cycles until fifo_read (-1 = any).
  // dropEnAt / rstAt: cycle offset from the pop at which tx_en drops / rst rises.
  task automatic runFrame(input int expWait, input int dropEnAt, input int rstAt);
    int         waited;
    int         pos;
    logic [7:0] b;
    logic       expTx;
    waited = 0;
    while (fifo_read !== 1'b1 && waited < 500) begin
      checkOutput("idle_tx", tx, 1);
      tick();
      waited++;
    end
    checkOutput("read_timeout", (waited < 500), 1);
    if (expWait >= 0) checkOutput("read_spacing", waited, expWait);
    if (fifo_read !== 1'b1 || fifoQ.size() == 0) return;
    b = fifoQ[0];
    checkOutput("tx_at_read", tx, 1);
    checkOutput("busy_at_read", busy, 1);
    for (int m = 1; m <= FRAME_END; m++) begin
      if (m == dropEnAt) tx_en = 1'b0;
      if (m == rstAt) rst = 1'b1;
      tick();
      if (m == rstAt) begin
        modelCnt = 0;
        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_read", fifo_read, 0);
        checkOutput("rst_cnt", frame_cnt, 0);
        rst = 1'b0;
        return;
      end
      if (m < 2 || m >= FRAME_END) begin
        expTx = 1'b1;
      end else begin
        pos = (m - 2) / C;
        if (pos == 0) expTx = 1'b0;
        else if (pos <= 8) expTx = b[pos-1];
        else expTx = 1'b1;
      end
      checkOutput("tx_bit", tx, expTx);
      checkOutput("read_pulse", fifo_read, 0);
      checkOutput("busy", busy, (m < FRAME_END));
      if (m == FRAME_END) modelCnt = (modelCnt + 1) % 65536;
      checkOutput("frame_cnt", frame_cnt, modelCnt);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    modelCnt   = 0;
    cycle      = 0;
    fifo_dout  = 8'h00;
    fifo_empty = 1'b1;
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);

    // Reset held three cycles with data waiting: nothing may move.
    pushByte(8'h3C);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset_tx", tx, 1);
      checkOutput("reset_read", fifo_read, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_cnt", frame_cnt, 0);
    end
    applyStimulus(1'b0, 1'b1);
    runFrame(1, -1, -1);

    // Single 0xA5 frame.
    pushByte(8'hA5);
    runFrame(1, -1, -1);

    // Back-to-back 0x00 then 0xFF: pops 43 cycles apart, 3-cycle idle gap.
    pushByte(8'h00);
    pushByte(8'hFF);
    runFrame(1, -1, -1);
    runFrame(1, -1, -1);
    checkOutput("b2b_cnt", frame_cnt, 4);

    // Empty FIFO for 200 cycles: line stays idle, no pops.
    for (int i = 0; i < 200; i++) begin
      tick();
      checkOutput("empty_read", fifo_read, 0);
      checkOutput("empty_tx", tx, 1);
      checkOutput("empty_busy", busy, 0);
    end

    // tx_en dropped mid-frame: frame finishes, next byte waits for enable.
    pushByte(8'h5A);
    pushByte(8'hC3);
    runFrame(1, 10, -1);
    for (int i = 0; i < 60; i++) begin
      tick();
      checkOutput("gated_read", fifo_read, 0);
      checkOutput("gated_tx", tx, 1);
    end
    applyStimulus(1'b0, 1'b1);
    runFrame(1, -1, -1);

    // Reset during data bit 3, then a normal frame on release.
    pushByte(8'h96);
    runFrame(1, -1, 2 + 4 * C + 1);
    pushByte(8'h69);
    runFrame(1, -1, -1);
    checkOutput("post_rst_cnt", frame_cnt, 1);

    // Randomized bytes with random idle gaps and occasional back-to-back pairs.
    for (int n = 0; n < 8; n++) begin
      int gap;
      gap = $urandom_range(0, 12);
      for (int i = 0; i < gap; i++) begin
        tick();
        checkOutput("rand_idle_read", fifo_read, 0);
      end
      pushByte(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        pushByte(8'($urandom));
        runFrame(1, -1, -1);
      end
      runFrame(1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the byte FIFO: pops one byte whenever the FIFO reports non-empty, serializes it as an 8N1 asynchronous frame on `tx`, and counts completed frames. It sits directly after the FIFO read port. Its read-side behaviour guarantees the FIFO's read-on-empty property is never exercised in normal operation.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Legal values are ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `tx_en`  in  1  permits starting a new frame. A frame already in progress always completes.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  8  FIFO read data. It is valid on the edge after the edge that samples `fifo_read` high (registered read).
- `fifo_read`  out  1  FIFO pop strobe; registered, one-cycle pulse per byte.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high in every state except IDLE.
- `frame_cnt`  out  16  number of completed frames; wraps modulo 2^16.

## Operation
- Reset values: `fifo_read`=0, `tx`=1, `busy`=0, `frame_cnt`=0, state=IDLE, baud counter=0, bit index=0.
- States: IDLE, READ, LATCH, START, DATA, STOP.
- IDLE → READ when `tx_en` && !`fifo_empty`. On the same edge `fifo_read` <= 1.
- Otherwise IDLE holds, with `fifo_read`=0.
- READ → LATCH unconditionally; `fifo_read` <= 0.
- LATCH → START. On this edge:
  - shift register <= `fifo_dout`
  - `tx` <= 0
  - baud counter <= 0
- START, DATA and STOP each last `CLKS_PER_BIT` cycles.
  - The baud counter runs 0..`CLKS_PER_BIT`-1; the bit ends on the edge where the counter equals `CLKS_PER_BIT`-1.
- START end → DATA: `tx` <= shreg[0], bit index <= 0.
- DATA bit end:
  - If index < 7: shift right, `tx` <= next bit, index++.
  - If index = 7: go to STOP with `tx` <= 1.
  - Bits are sent LSB first.
- STOP end → IDLE: `frame_cnt` <= `frame_cnt`+1, wrapping 0xFFFF → 0x0000.
  - IDLE evaluates FIFO state on the following edge. There is no direct STOP → READ path.
- `fifo_read` is asserted only from IDLE with `fifo_empty` sampled low, so exactly one pop occurs per frame. A read-on-empty is never issued.
- Deasserting `tx_en` outside IDLE has no effect on the current frame. It only blocks the next IDLE → READ transition.
- Changes of `fifo_empty` after the IDLE → READ edge are ignored; the popped byte is always transmitted.
- Reset mid-frame: all outputs return to their reset values on that edge.
  - `tx` goes high immediately, producing a truncated frame.
  - The popped byte is discarded and `frame_cnt` does not count it.

## Timing
- Let edge k be the edge on which IDLE sees `tx_en`=1 and `fifo_empty`=0.
- `fifo_read`=1 during cycle (k, k+1]; the FIFO pops at edge k+1.
- `tx` falls at edge k+2, which is the start-bit start.
- Data bit i spans edges k+2+C(1+i) to k+2+C(2+i), where C = `CLKS_PER_BIT`.
- Stop bit spans k+2+9C to k+2+10C. At edge k+2+10C the state is IDLE and `frame_cnt` increments.
- Next earliest `fifo_read` rise is at edge k+3+10C.
- Back-to-back frame period: 10C+3 cycles. The idle-high gap between a stop bit and the next start bit is 3 cycles.
- Latency from `fifo_empty` falling (sampled at edge k) to `tx` start: 2 cycles.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `fifo_empty`=0, then release. Outputs must read `tx`=1, `fifo_read`=0, `busy`=0, `frame_cnt`=0 throughout reset. The first `fifo_read` must rise on the first edge after release.
- Single byte, C=4, `fifo_dout`=0xA5:
  - Exactly one `fifo_read` pulse.
  - `tx` sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1.
  - `frame_cnt`=1; `busy` low 42 cycles after `fifo_read` rises.
- Back-to-back, C=4, bytes 0x00 then 0xFF with `fifo_empty`=0 throughout:
  - `fifo_read` pulses are 43 cycles apart.
  - The gap between the stop bit and the second start bit is 3 cycles high.
  - `frame_cnt`=2.
- Empty / enable gating:
  - `fifo_empty`=1 for 200 cycles: no `fifo_read`, `tx`=1.
  - `tx_en`=0 mid-frame: the frame completes, `frame_cnt` increments, and no further `fifo_read` occurs while `fifo_empty`=0.
- Reset mid-frame: assert `rst` during DATA bit 3. The next edge must give `tx`=1, `busy`=0 and unchanged `frame_cnt`=0. After release, transmission of the next FIFO byte starts normally.
- Counter wrap: preload by running 65536 frames with C=2. `frame_cnt` goes 0xFFFF → 0x0000 on the 65536th stop-bit end.
